// File: rtl/bldcm_avmm_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bldcm_avmm_master_pkg
// Description : Shared definitions for the BLDC motor Avalon-MM command master.
//               Holds the command op encodings, bus response codes, register
//               word addresses, the FSM state type and the ramp step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bldcm_avmm_master_pkg;

    // Command op encodings (iCmdOp)
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RAMP  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Avalon-MM response codes
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;
    localparam logic [1:0] RESP_DECODEERR = 2'b11;

    // Slave register word addresses
    localparam logic [1:0] ADDR_FREQ   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD        = 4'd1,
        RD_WAIT   = 4'd2,
        WR        = 4'd3,
        WR_WAIT   = 4'd4,
        RAMP_WAIT = 4'd5,
        RAMP_WR   = 4'd6,
        RAMP_RSP  = 4'd7,
        DONE      = 4'd8
    } state_e;

    // Next frequency on the way from cur to tgt. The distance is compared
    // against the step before adding/subtracting, so the result lands exactly
    // on the target instead of overshooting or wrapping past 32 bits.
    function automatic logic [31:0] ramp_next(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
        logic [31:0] w_res;
        if (tgt > cur) begin
            w_res = ((tgt - cur) <= step) ? tgt : (cur + step);
        end else begin
            w_res = ((cur - tgt) <= step) ? tgt : (cur - step);
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bldcm_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : bldcm_tick_div
// Description : Ramp pacing divider. oTick-style one-cycle pulse every pDiv
//               cycles. The cycle in which clr_i is high counts as the first
//               cycle of a fresh period, so a pulse arrives exactly pDiv
//               cycles after the clear cycle began.
// Ports       : clk_i   - clock (rising edge)
//               rst_ni  - asynchronous active-low reset
//               clr_i   - restart the period
//               tick_o  - one-cycle pulse at the end of each period
// Revision    : 1.0 - initial release
// ============================================================================
module bldcm_tick_div #(
    parameter logic [31:0] pDiv = 32'd50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    // Zero is not a legal divide; treat it as divide-by-one.
    localparam logic [31:0] C_LAST = (pDiv == 32'd0) ? 32'd0 : (pDiv - 32'd1);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] w_cur;

    always_comb begin
        w_cur  = clr_i ? 32'd0 : cnt_q;
        tick_o = (w_cur == C_LAST);
        cnt_d  = tick_o ? 32'd0 : (w_cur + 32'd1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bldcm_avmm_master.sv
`default_nettype none
// ============================================================================
// Module      : bldcm_avmm_master
// Description : Command-driven Avalon-MM master for a BLDC motor controller.
//               Executes single reads/writes and paced frequency ramps that
//               step the FREQ register toward a target, tracking the last
//               successfully written frequency in rFreqCur.
// Ports       : iClock/iReset_n          - clock, async active-low reset
//               iCmdValid/oCmdReady      - command handshake
//               iCmdOp/Addr/Data/Step    - command fields
//               oRspValid/Data/Resp      - one-cycle completion + held result
//               oBusy                    - command in flight
//               oAddr/oRead/iRdata/oWrite/oWdata/iResp - Avalon-MM master bus
// Revision    : 1.0 - initial release
// ============================================================================
module bldcm_avmm_master #(
    parameter int          pRdLatency = 1,
    parameter logic [31:0] pRampDiv   = 32'd50000
) (
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic        iCmdValid,
    output logic        oCmdReady,
    input  logic [1:0]  iCmdOp,
    input  logic [1:0]  iCmdAddr,
    input  logic [31:0] iCmdData,
    input  logic [31:0] iCmdStep,
    output logic        oRspValid,
    output logic [31:0] oRspData,
    output logic [1:0]  oRspResp,
    output logic        oBusy,
    output logic [1:0]  oAddr,
    output logic        oRead,
    input  logic [31:0] iRdata,
    output logic        oWrite,
    output logic [31:0] oWdata,
    input  logic [1:0]  iResp
);

    import bldcm_avmm_master_pkg::*;

    state_e      state_q;
    logic        cmd_ready_q;
    logic        busy_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [1:0]  rsp_resp_q;
    logic [1:0]  addr_q;
    logic        read_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [31:0] rFreqCur;
    logic [1:0]  op_addr_q;   // captured command address
    logic [31:0] op_data_q;   // captured write data / ramp target
    logic [31:0] step_q;      // ramp increment, never zero
    logic [31:0] step_val_q;  // ramp value on the bus awaiting its response
    logic [2:0]  lat_cnt_q;
    logic        tick_clr_q;

    logic        w_tick;
    logic [31:0] w_ramp_next;

    assign w_ramp_next = ramp_next(rFreqCur, op_data_q, step_q);

    bldcm_tick_div #(
        .pDiv (pRampDiv)
    ) u_tick_div (
        .clk_i  (iClock),
        .rst_ni (iReset_n),
        .clr_i  (tick_clr_q),
        .tick_o (w_tick)
    );

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_resp_q  <= RESP_OKAY;
            addr_q      <= 2'd0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 32'd0;
            rFreqCur    <= 32'd0;
            op_addr_q   <= 2'd0;
            op_data_q   <= 32'd0;
            step_q      <= 32'd1;
            step_val_q  <= 32'd0;
            lat_cnt_q   <= 3'd0;
            tick_clr_q  <= 1'b0;
        end else begin
            tick_clr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    if (iCmdValid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        op_addr_q   <= iCmdAddr;
                        op_data_q   <= iCmdData;
                        step_q      <= (iCmdStep == 32'd0) ? 32'd1 : iCmdStep;
                        case (iCmdOp)
                            OP_READ: begin
                                read_q  <= 1'b1;
                                addr_q  <= iCmdAddr;
                                state_q <= RD;
                            end
                            OP_WRITE: begin
                                write_q <= 1'b1;
                                addr_q  <= iCmdAddr;
                                wdata_q <= iCmdData;
                                state_q <= WR;
                            end
                            OP_RAMP: begin
                                if (iCmdData == rFreqCur) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= rFreqCur;
                                    rsp_resp_q  <= RESP_OKAY;
                                    state_q     <= DONE;
                                end else begin
                                    tick_clr_q <= 1'b1;
                                    state_q    <= RAMP_WAIT;
                                end
                            end
                            default: begin
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= 32'd0;
                                rsp_resp_q  <= RESP_DECODEERR;
                                state_q     <= DONE;
                            end
                        endcase
                    end
                end
                RD: begin
                    read_q    <= 1'b0;
                    addr_q    <= 2'd0;
                    lat_cnt_q <= 3'd1;
                    state_q   <= RD_WAIT;
                end
                RD_WAIT: begin
                    // lat_cnt_q counts cycles elapsed since the oRead cycle
                    if (lat_cnt_q == 3'(pRdLatency)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= iRdata;
                        rsp_resp_q  <= iResp;
                        state_q     <= DONE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                WR: begin
                    write_q <= 1'b0;
                    addr_q  <= 2'd0;
                    wdata_q <= 32'd0;
                    state_q <= WR_WAIT;
                end
                WR_WAIT: begin
                    if ((iResp == RESP_OKAY) && (op_addr_q == ADDR_FREQ)) begin
                        rFreqCur <= op_data_q;
                    end
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= op_data_q;
                    rsp_resp_q  <= iResp;
                    state_q     <= DONE;
                end
                RAMP_WAIT: begin
                    if (w_tick) begin
                        write_q    <= 1'b1;
                        addr_q     <= ADDR_FREQ;
                        wdata_q    <= w_ramp_next;
                        step_val_q <= w_ramp_next;
                        state_q    <= RAMP_WR;
                    end
                end
                RAMP_WR: begin
                    write_q <= 1'b0;
                    addr_q  <= 2'd0;
                    wdata_q <= 32'd0;
                    state_q <= RAMP_RSP;
                end
                RAMP_RSP: begin
                    if (iResp != RESP_OKAY) begin
                        // Abort keeps the last frequency the slave accepted
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rFreqCur;
                        rsp_resp_q  <= iResp;
                        state_q     <= DONE;
                    end else begin
                        rFreqCur <= step_val_q;
                        if (step_val_q == op_data_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= step_val_q;
                            rsp_resp_q  <= RESP_OKAY;
                            state_q     <= DONE;
                        end else begin
                            tick_clr_q <= 1'b1;
                            state_q    <= RAMP_WAIT;
                        end
                    end
                end
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oCmdReady = cmd_ready_q;
    assign oBusy     = busy_q;
    assign oRspValid = rsp_valid_q;
    assign oRspData  = rsp_data_q;
    assign oRspResp  = rsp_resp_q;
    assign oAddr     = addr_q;
    assign oRead     = read_q;
    assign oWrite    = write_q;
    assign oWdata    = wdata_q;

endmodule
`default_nettype wire

// File: doc/bldcm_avmm_master.md
BLDCM_AVMM_MASTER -- requirements
Module: bldcm_avmm_master

Interface
REQ-001 The block SHALL have parameter pRdLatency, default 1: cycles from oRead assertion to iRdata/iResp valid, legal range 1..4.
REQ-002 The block SHALL have parameter pRampDiv, default 32'd50000: clock cycles between consecutive ramp writes, minimum 1.
REQ-003 The block SHALL have port iClock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port iReset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iCmdValid, input, 1 bit: command request.
REQ-006 The block SHALL have port oCmdReady, output, 1 bit: command accepted when iCmdValid and oCmdReady are both high.
REQ-007 The block SHALL have port iCmdOp, input, 2 bits: 00 read, 01 write, 10 ramp, 11 reserved.
REQ-008 The block SHALL have port iCmdAddr, input, 2 bits: target word address for read/write.
REQ-009 The block SHALL have port iCmdData, input, 32 bits: write data, or the ramp target frequency.
REQ-010 The block SHALL have port iCmdStep, input, 32 bits: ramp increment per step.
REQ-011 The block SHALL have port oRspValid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have ports oRspData, output, 32 bits (read data or final frequency), and oRspResp, output, 2 bits (00 OKAY, 10 SLVERR, 11 DECODEERR).
REQ-013 The block SHALL have port oBusy, output, 1 bit: high from command acceptance through the oRspValid cycle.
REQ-014 The block SHALL have Avalon-MM master ports oAddr (output, 2 bits), oRead (output, 1 bit), iRdata (input, 32 bits), oWrite (output, 1 bit), oWdata (output, 32 bits) and iResp (input, 2 bits).

Function
REQ-015 oCmdReady SHALL be high only in IDLE; commands SHALL NOT be accepted while busy.
REQ-016 The FSM SHALL have the states IDLE, RD, RD_WAIT, WR, WR_WAIT, RAMP_WAIT, RAMP_WR, RAMP_RSP and DONE.
REQ-017 A read SHALL go IDLE->RD, assert oRead for exactly one cycle with oAddr=iCmdAddr, go to RD_WAIT, sample iRdata/iResp pRdLatency cycles after oRead, then go to DONE.
REQ-018 A write SHALL go IDLE->WR, assert oWrite for exactly one cycle with oAddr/oWdata, go to WR_WAIT, sample iResp on the next cycle, then go to DONE.
REQ-019 oRead and oWrite SHALL never be high together; oAddr and oWdata SHALL be 0 when neither is asserted.
REQ-020 DONE SHALL assert oRspValid for one cycle and return to IDLE; oRspData/oRspResp SHALL hold until the next response.
REQ-021 Register rFreqCur (32 bits) SHALL load oWdata on every OKAY write to address 0.
REQ-022 Ramp, when iCmdData equals rFreqCur, SHALL go directly to DONE with OKAY and data=rFreqCur and SHALL NOT make a bus cycle.
REQ-023 Ramp SHALL otherwise loop RAMP_WAIT (pRampDiv cycles) -> RAMP_WR (write to address 0) -> RAMP_RSP.
REQ-024 Each ramp step SHALL be rFreqCur+step toward a higher target, or rFreqCur-step toward a lower target, saturated at the target with no 32-bit wrap; a step of 0 SHALL be treated as 1.
REQ-025 RAMP_RSP with a non-OKAY iResp SHALL abort to DONE with that code and data=rFreqCur unchanged.
REQ-026 RAMP_RSP SHALL go to DONE with OKAY once the target is written, and otherwise return to RAMP_WAIT.
REQ-027 Op 11 SHALL complete through DONE with DECODEERR and data 0, with no bus cycle.

Reset
REQ-028 On iReset_n low, asynchronously: FSM=IDLE; rFreqCur, oRspData, oAddr and oWdata = 0; oRspResp=00; oRead, oWrite, oRspValid and oBusy = 0; oCmdReady=0 while in reset and 1 in the first cycle after release.
REQ-029 Reset mid-transaction SHALL abandon the operation with no response pulse.

Structure
REQ-030 A shared package SHALL hold the op encodings, the response codes, the FSM state enum and the register addresses (FREQ=0, STATUS=3).
REQ-031 The ramp divider SHALL be one sub-module, bldcm_tick_div, producing a one-cycle tick every pRampDiv cycles with clear on entry to RAMP_WAIT.

Verification
REQ-032 Read addr 3, slave returns 0x00000005/OKAY at latency 1 -> single oRead pulse, then oRspValid with data 0x5, resp 00.
REQ-033 Write addr 0 data 2083333 -> single oWrite pulse with oWdata=2083333, resp 00, rFreqCur=2083333.
REQ-034 Read addr 2, slave returns resp 11 -> oRspResp=11; then write addr 2 -> oRspResp=11 and rFreqCur unchanged.
REQ-035 Ramp from 0 to 10 with step 4, pRampDiv=3 -> writes 4, 8, 10 spaced 3+ cycles apart, then OKAY data 10; ramp 10->10 -> immediate response with no bus cycle.
REQ-036 Ramp 0xFFFFFFF0 -> 0xFFFFFFFF with step 0x20 -> a single write of 0xFFFFFFFF; iReset_n low mid-ramp -> outputs zero immediately and no oRspValid.
